// File: rtl/tc_program_loader.sv
// Byte-stream program loader: packs bytes LSB-first into words and writes
// them sequentially from address 0 into the program RAM write port.
module tc_program_loader #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int WORD_COUNT = 65536
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [7:0]            i_byte_in,
   input  logic                  i_byte_valid,
   input  logic                  i_byte_last,
   output logic                  o_byte_ready,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [WORD_WIDTH-1:0] o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overflow,
   output logic [ADDR_WIDTH:0]   o_words_written
);

   localparam int BPW   = WORD_WIDTH / 8;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(BPW - 1);
   localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
   localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(WORD_COUNT);
   localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [IDX_W-1:0]      r_idx;
   logic [WORD_WIDTH-1:0] r_buffer;
   logic [ADDR_WIDTH:0]   r_addrCnt;
   logic [ADDR_WIDTH:0]   r_wordsWritten;
   logic                  r_wrEn;
   logic [ADDR_WIDTH-1:0] r_wrAddr;
   logic [WORD_WIDTH-1:0] r_wrData;
   logic                  r_overflow;

   logic                  w_accept;
   logic                  w_wordEnd;
   logic                  w_restart;
   logic [WORD_WIDTH-1:0] w_packed;

   assign w_accept  = (r_state == ST_LOAD) && i_byte_valid;
   assign w_wordEnd = w_accept && ((r_idx == LAST_IDX) || i_byte_last);
   assign w_restart = (r_state != ST_LOAD) && i_start;

   // Current buffer with the incoming byte merged into its lane; lanes not yet filled stay zero.
   always_comb begin
      w_packed = r_buffer;
      for (int k = 0; k < BPW; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_packed[8*k +: 8] = i_byte_in;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_nextState = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_accept && i_byte_last) begin
               w_nextState = ST_DONE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Words beyond WORD_COUNT are packed and dropped so the stream still drains up to byte_last.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx          <= '0;
         r_buffer       <= '0;
         r_addrCnt      <= '0;
         r_wordsWritten <= '0;
         r_wrEn         <= 1'b0;
         r_wrAddr       <= '0;
         r_wrData       <= '0;
         r_overflow     <= 1'b0;
      end else begin
         r_wrEn <= 1'b0;
         if (w_restart) begin
            r_idx          <= '0;
            r_buffer       <= '0;
            r_addrCnt      <= '0;
            r_wordsWritten <= '0;
            r_overflow     <= 1'b0;
         end else if (w_wordEnd) begin
            if (r_addrCnt < WORD_LIMIT) begin
               r_wrEn         <= 1'b1;
               r_wrAddr       <= r_addrCnt[ADDR_WIDTH-1:0];
               r_wrData       <= w_packed;
               r_addrCnt      <= r_addrCnt + CNT_ONE;
               r_wordsWritten <= r_wordsWritten + CNT_ONE;
            end else begin
               r_overflow <= 1'b1;
            end
            r_idx    <= '0;
            r_buffer <= '0;
         end else if (w_accept) begin
            r_buffer <= w_packed;
            r_idx    <= r_idx + IDX_ONE;
         end
      end
   end

   assign o_byte_ready    = (r_state == ST_LOAD);
   assign o_busy          = (r_state == ST_LOAD);
   assign o_done          = (r_state == ST_DONE);
   assign o_wr_en         = r_wrEn;
   assign o_wr_addr       = r_wrAddr;
   assign o_wr_data       = r_wrData;
   assign o_overflow      = r_overflow;
   assign o_words_written = r_wordsWritten;

endmodule

// File: tb/tb_tc_program_loader.sv
// Scoreboard bench: one byte stream drives three loader variants (16-bit, 32-bit,
// 16-bit with a 4-word RAM); a per-variant model queues the writes each should make.
module tb_tc_program_loader;

   typedef struct {
      int          stamp;
      int          addr;
      logic [63:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic        valid;
   logic        last;
   logic [7:0]  byteIn;

   logic        readyA, wrEnA, busyA, doneA, ovfA;
   logic [15:0] wrAddrA;
   logic [15:0] wrDataA;
   logic [16:0] wwA;
   logic        readyB, wrEnB, busyB, doneB, ovfB;
   logic [15:0] wrAddrB;
   logic [31:0] wrDataB;
   logic [16:0] wwB;
   logic        readyC, wrEnC, busyC, doneC, ovfC;
   logic [1:0]  wrAddrC;
   logic [15:0] wrDataC;
   logic [2:0]  wwC;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int          mBpw[3] = '{2, 4, 2};
   int          mWc[3]  = '{65536, 65536, 4};
   int          mState[3];
   int          mIdx[3];
   int          mAddr[3];
   int          mWords[3];
   logic        mOvf[3];
   logic [63:0] mBuf[3];
   wr_t         expQ[3][$];

   int          lastAddr[3];
   logic [63:0] lastData[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tc_program_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .WORD_COUNT(65536)) dutA (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_byte_in(byteIn),
      .i_byte_valid(valid), .i_byte_last(last), .o_byte_ready(readyA),
      .o_wr_en(wrEnA), .o_wr_addr(wrAddrA), .o_wr_data(wrDataA), .o_busy(busyA),
      .o_done(doneA), .o_overflow(ovfA), .o_words_written(wwA));

   tc_program_loader #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .WORD_COUNT(65536)) dutB (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_byte_in(byteIn),
      .i_byte_valid(valid), .i_byte_last(last), .o_byte_ready(readyB),
      .o_wr_en(wrEnB), .o_wr_addr(wrAddrB), .o_wr_data(wrDataB), .o_busy(busyB),
      .o_done(doneB), .o_overflow(ovfB), .o_words_written(wwB));

   tc_program_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(2), .WORD_COUNT(4)) dutC (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_byte_in(byteIn),
      .i_byte_valid(valid), .i_byte_last(last), .o_byte_ready(readyC),
      .o_wr_en(wrEnC), .o_wr_addr(wrAddrC), .o_wr_data(wrDataC), .o_busy(busyC),
      .o_done(doneC), .o_overflow(ovfC), .o_words_written(wwC));

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic getStatus(input int d, output logic ready, output logic busy,
                            output logic done, output logic ovf, output logic [63:0] ww);
      case (d)
         0:       begin ready = readyA; busy = busyA; done = doneA; ovf = ovfA; ww = 64'(wwA); end
         1:       begin ready = readyB; busy = busyB; done = doneB; ovf = ovfB; ww = 64'(wwB); end
         default: begin ready = readyC; busy = busyC; done = doneC; ovf = ovfC; ww = 64'(wwC); end
      endcase
   endtask

   task automatic getWrite(input int d, output logic en, output logic [63:0] a, output logic [63:0] dt);
      case (d)
         0:       begin en = wrEnA; a = 64'(wrAddrA); dt = 64'(wrDataA); end
         1:       begin en = wrEnB; a = 64'(wrAddrB); dt = 64'(wrDataB); end
         default: begin en = wrEnC; a = 64'(wrAddrC); dt = 64'(wrDataC); end
      endcase
   endtask

   task automatic checkStatus();
      logic ready, busy, done, ovf;
      logic [63:0] ww;
      for (int d = 0; d < 3; d++) begin
         getStatus(d, ready, busy, done, ovf, ww);
         checkOutput($sformatf("ready%0d", d), 64'(ready), 64'(mState[d] == 1));
         checkOutput($sformatf("busy%0d", d), 64'(busy), 64'(mState[d] == 1));
         checkOutput($sformatf("done%0d", d), 64'(done), 64'(mState[d] == 2));
         checkOutput($sformatf("overflow%0d", d), 64'(ovf), 64'(mOvf[d]));
         checkOutput($sformatf("wordsWritten%0d", d), ww, 64'(mWords[d]));
      end
   endtask

   task automatic checkZeros();
      logic ready, busy, done, ovf, en;
      logic [63:0] ww, a, dt;
      for (int d = 0; d < 3; d++) begin
         getStatus(d, ready, busy, done, ovf, ww);
         getWrite(d, en, a, dt);
         checkOutput($sformatf("rstReady%0d", d), 64'(ready), 64'd0);
         checkOutput($sformatf("rstBusy%0d", d), 64'(busy), 64'd0);
         checkOutput($sformatf("rstDone%0d", d), 64'(done), 64'd0);
         checkOutput($sformatf("rstOverflow%0d", d), 64'(ovf), 64'd0);
         checkOutput($sformatf("rstWords%0d", d), ww, 64'd0);
         checkOutput($sformatf("rstWrEn%0d", d), 64'(en), 64'd0);
         checkOutput($sformatf("rstWrAddr%0d", d), a, 64'd0);
         checkOutput($sformatf("rstWrData%0d", d), dt, 64'd0);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 3; d++) begin
         mState[d] = 0; mIdx[d] = 0; mAddr[d] = 0; mWords[d] = 0;
         mOvf[d] = 1'b0; mBuf[d] = '0;
      end
   endtask

   // Reference behaviour for one rising edge; completed words are queued for the following cycle.
   task automatic modelStep(input int d, input logic s, input logic [7:0] b, input logic v, input logic l);
      wr_t e;
      if (mState[d] != 1) begin
         if (s) begin
            mState[d] = 1; mIdx[d] = 0; mAddr[d] = 0; mWords[d] = 0;
            mOvf[d] = 1'b0; mBuf[d] = '0;
         end
      end else if (v) begin
         mBuf[d][8*mIdx[d] +: 8] = b;
         if (mIdx[d] == mBpw[d] - 1 || l) begin
            if (mAddr[d] < mWc[d]) begin
               e.stamp = cyc + 1;
               e.addr  = mAddr[d];
               e.data  = mBuf[d];
               expQ[d].push_back(e);
               mAddr[d]++;
               mWords[d]++;
            end else begin
               mOvf[d] = 1'b1;
            end
            mIdx[d] = 0;
            mBuf[d] = '0;
         end else begin
            mIdx[d]++;
         end
         if (l) mState[d] = 2;
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] b, input logic v, input logic l);
      @(negedge clk);
      checkStatus();
      start = s; byteIn = b; valid = v; last = l;
      for (int d = 0; d < 3; d++) modelStep(d, s, b, v, l);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic resetMidLoad();
      @(negedge clk);
      checkStatus();
      start = 1'b0; valid = 1'b0; last = 1'b0;
      #2 rstN = 1'b0;
      #1 checkZeros();
      modelReset();
      @(negedge clk);
      rstN = 1'b1;
   endtask

   // Write monitor: every write must match the queue head and land on its expected cycle.
   always @(negedge clk) begin
      logic        en;
      logic        expEn;
      logic [63:0] a;
      logic [63:0] dt;
      wr_t         e;
      for (int d = 0; d < 3; d++) begin
         getWrite(d, en, a, dt);
         expEn = (expQ[d].size() > 0) && (expQ[d][0].stamp <= cyc);
         if (en || expEn) checkOutput($sformatf("wrEn%0d", d), 64'(en), 64'(expEn));
         if (expEn) begin
            e = expQ[d].pop_front();
            if (en) begin
               checkOutput($sformatf("wrAddr%0d", d), a, 64'(e.addr));
               checkOutput($sformatf("wrData%0d", d), dt, e.data);
               checkOutput($sformatf("wrCycle%0d", d), 64'(cyc), 64'(e.stamp));
            end
         end
         if (en) begin
            lastAddr[d] = int'(a);
            lastData[d] = dt;
         end
      end
   end

   initial begin
      rstN = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; byteIn = 8'h00;
      modelReset();
      @(negedge clk);
      checkZeros();
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] full words, valid held high");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h34, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h12, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h78, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h56, 1'b1, 1'b1);
      idleCycles(3);
      checkOutput("t1LastDataA", lastData[0], 64'h5678);
      checkOutput("t1LastDataB", lastData[1], 64'h56781234);
      checkOutput("t1WordsA", 64'(wwA), 64'd2);
      checkOutput("t1DoneA", 64'(doneA), 64'd1);
      checkOutput("t1OverflowA", 64'(ovfA), 64'd0);

      $display("[TB] partial final word");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hAA, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hBB, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hCC, 1'b1, 1'b1);
      idleCycles(2);
      checkOutput("t2LastDataA", lastData[0], 64'h00CC);
      checkOutput("t2LastAddrA", 64'(lastAddr[0]), 64'd1);
      checkOutput("t2WordsA", 64'(wwA), 64'd2);

      $display("[TB] random valid gaps");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'($urandom));
         applyStimulus(1'b0, 8'(i), 1'b1, 1'(i == 8));
      end
      idleCycles(2);
      checkOutput("t3LastDataB", lastData[1], 64'h08070605);
      checkOutput("t3LastAddrB", 64'(lastAddr[1]), 64'd1);

      $display("[TB] image larger than small RAM");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) applyStimulus(1'b0, 8'(8'h40 + i), 1'b1, 1'(i == 12));
      idleCycles(2);
      checkOutput("t4OverflowC", 64'(ovfC), 64'd1);
      checkOutput("t4WordsC", 64'(wwC), 64'd4);
      checkOutput("t4DoneC", 64'(doneC), 64'd1);
      checkOutput("t4LastAddrC", 64'(lastAddr[2]), 64'd3);
      checkOutput("t4WordsA", 64'(wwA), 64'd6);

      $display("[TB] reset mid-load");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hA1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hA2, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hA3, 1'b1, 1'b0);
      resetMidLoad();
      idleCycles(2);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h11, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h22, 1'b1, 1'b1);
      idleCycles(2);
      checkOutput("t5LastDataA", lastData[0], 64'h2211);
      checkOutput("t5LastAddrA", 64'(lastAddr[0]), 64'd0);
      checkOutput("t5WordsA", 64'(wwA), 64'd1);

      $display("[TB] restart from DONE, start ignored in LOAD");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h55, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h77, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h88, 1'b1, 1'b1);
      idleCycles(3);
      checkOutput("t6LastDataA", lastData[0], 64'h8877);
      checkOutput("t6LastAddrA", 64'(lastAddr[0]), 64'd1);
      checkOutput("t6WordsA", 64'(wwA), 64'd2);
      checkOutput("t6OverflowC", 64'(ovfC), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tc_program_loader.md
Name: tc_program_loader

Overview:
- Writer-side counterpart of the program memory.
- Accepts a byte stream under a valid/ready handshake and packs bytes into words, least-significant byte first.
- Byte k of each word lands in bits [8k+7:8k], the same layout the program memory uses when it reads its image file.
- Issues sequential single-word writes from address 0 into the program RAM write port. Used to download a program image at boot or under debugger control.

Parameters:
WORD_WIDTH, 16, program word width in bits; legal values 8, 16, 32, 64; BPW = WORD_WIDTH/8 bytes per word
ADDR_WIDTH, 16, width of write address
WORD_COUNT, 65536, number of writable words; must be <= 2^ADDR_WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  begin a load; honoured only in IDLE or DONE
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  one-cycle write strobe to program RAM
wr_addr  output  ADDR_WIDTH  word address of write
wr_data  output  WORD_WIDTH  packed word
busy  output  1  high in LOAD
done  output  1  high in DONE
overflow  output  1  sticky; image exceeded WORD_COUNT words
words_written  output  ADDR_WIDTH+1  count of words written in current/last load

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE.
  - All outputs 0: byte_ready, wr_en, wr_addr, wr_data, busy, done, overflow, words_written.
  - Internal pack buffer, byte index and address counter cleared.
- States: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD. On that edge clear addr, byte index, buffer, words_written and overflow.
  - DONE: identical to IDLE for start; otherwise holds.
  - LOAD: start ignored.
- byte_ready = (state==LOAD), combinational from state. A byte is accepted on a rising edge where byte_valid & byte_ready.
- On acceptance: buffer[8*idx+7:8*idx] <= byte_in and idx <= idx+1.
- Word completes when the accepted byte has idx==BPW-1 or byte_last=1. On the completing edge:
  - If addr < WORD_COUNT:
    - wr_en <= 1.
    - wr_addr <= addr.
    - wr_data <= packed word; bytes not yet received are zero.
    - addr <= addr+1; words_written <= words_written+1.
  - Otherwise: no write and overflow <= 1. Bytes continue to be accepted and discarded until byte_last.
  - In both cases idx <= 0 and buffer cleared.
- Write latency: wr_en/wr_addr/wr_data are registered and valid exactly the cycle after the completing byte is accepted. wr_en is high for exactly one cycle per word. wr_addr/wr_data hold their last values while wr_en=0.
- Back-to-back writes:
  - BPW=1 with byte_valid held high gives wr_en high on consecutive cycles with incrementing addresses.
  - No write is ever dropped; the RAM write port is assumed always ready.
- byte_last:
  - On the edge that accepts it, state <= DONE, after any flush write.
  - done rises the same cycle wr_en shows the final word.
  - byte_last with byte_valid=0 is ignored.
- busy = (state==LOAD). done = (state==DONE). Both are registered state decodes.
- Address counter is ADDR_WIDTH+1 bits internally, so WORD_COUNT=2^ADDR_WIDTH does not wrap. Addresses never wrap; overflow is flagged instead.
- Reset mid-load abandons any partial word; no write is issued for it.

Test Plan:
- WORD_WIDTH=16: start, bytes 0x34,0x12,0x78,0x56 (last on 0x56), valid held high -> wr_en cycles write addr0=0x1234 and addr1=0x5678; done=1 with the second write; words_written=2; overflow=0.
- WORD_WIDTH=16 partial: bytes 0xAA,0xBB,0xCC (last on 0xCC) -> addr0=0xBBAA, addr1=0x00CC; words_written=2.
- WORD_WIDTH=32 with random byte_valid gaps: 8 bytes 0x01..0x08 -> addr0=0x04030201, addr1=0x08070605; each wr_en one cycle after the 4th/8th accepted byte; byte_ready=0 outside LOAD.
- WORD_COUNT=4, WORD_WIDTH=16: 12 bytes, last on 12th -> exactly 4 writes (addr 0..3), overflow=1, words_written=4, done=1; all 12 bytes accepted.
- Reset mid-load: rst=0 after 3 of 4 bytes -> all outputs 0 asynchronously, no further wr_en. Then start plus 2 bytes 0x11,0x22 with last -> single write addr0=0x2211.
- Restart from DONE: start -> words_written and overflow clear; next load writes again from addr0. A start pulse during LOAD has no effect.
